interrupt_controller: RTL and testbench
=======================================

# interrupt_controller

Prioritising interrupt controller that sits on the IO side of the CPU and schedules up to eight external interrupt sources onto the CPU's single `io_interrupt` request. It edge-detects and latches requests, applies a software mask, selects the highest-priority unmasked source, and holds the handshake until the CPU takes the interrupt. It stores the CPU return address and drives the vector, pending status and return address onto `d_bus` when the control unit strobes the matching push line.

## Interface

- `VECTOR_BASE`, 16'hFF00, base address of the vector table; entries are 4 words apart.
- `MASK_ADDR`, 4'h0, IO address of the mask register.
- `EOI_ADDR`, 4'h1, IO address of the end-of-interrupt command.
- `CLR_ADDR`, 4'h2, IO address of the write-1-to-clear pending register.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `irq`  in  8  interrupt sources, synchronous to `clk`; bit 0 has the highest priority.
- `io_interrupt`  out  1  registered interrupt request to the control unit.
- `io_store_retaddr`  in  1  CPU accepts the interrupt; latch `d_addr` as the return address.
- `io_push_retaddr`  in  1  drive the stored return address on `d_bus`.
- `io_push_ints`  in  1  drive {in_service_id[2:0], in_service, 4'b0, pending[7:0]} on `d_bus`.
- `io_push_int_addr`  in  1  drive the vector of the selected source on `d_bus`.
- `io_write`  in  1  IO register write strobe, qualified by `io_addr`.
- `io_addr`  in  4  IO register address.
- `d_addr`  in  16  address bus; source of the return address.
- `d_bus`  inout  16  data bus; tri-stated unless a push strobe is high.

## Operation

- Edge detect: `irq_q` holds the previous value of `irq`. For each bit, `irq & ~irq_q` sets `pending[i]`.
- Pending clear: `io_write` to `CLR_ADDR` clears `pending` bits where `d_bus[7:0]` is 1. A new edge in the same cycle wins, so the bit stays set.
- Mask: `io_write` to `MASK_ADDR` loads `mask` from `d_bus[7:0]`. A 1 masks the source. Masked sources still latch as pending.
- Eligible set: `pending & ~mask`. The winner `sel_id` is the lowest set index.
- State machine IDLE / REQ / SERVICE:
  - IDLE: if the eligible set is non-empty, register `sel_id` into `cur_id`, set `io_interrupt`=1 and go to REQ.
  - REQ: `cur_id` is frozen. Later edges, mask writes and clear writes do not change it or withdraw the request.
  - REQ, on `io_store_retaddr`: latch `retaddr`←`d_addr`, clear `pending[cur_id]`, set `in_service`, drop `io_interrupt` and go to SERVICE.
  - SERVICE: no nesting. On `io_write` to `EOI_ADDR`, clear `in_service` and return to IDLE.
  - SERVICE, other input: `io_store_retaddr` has no effect.
- Vector: `VECTOR_BASE + {11'b0, cur_id, 2'b00}`, 16-bit modulo (wraps silently).
- Bus drive: combinational from registered state while the strobe is high.
  - Push priority if more than one strobe is high: `io_push_int_addr` > `io_push_retaddr` > `io_push_ints`.
  - Otherwise `d_bus` is 16'hzzzz.
- Writes to unmapped `io_addr` values are ignored.

## Timing

- Reset values: state=IDLE, `io_interrupt`=0, `pending`=0, `mask`=8'hFF (all masked), `irq_q`=0, `retaddr`=0, `cur_id`=0, `in_service`=0, `d_bus` released.
- Reset mid-handshake aborts immediately: the request drops asynchronously and no state is retained.
- Latency:
  - `irq` rises in cycle N; `pending` is set at edge N+1.
  - `io_interrupt` goes high at edge N+2 if the source is eligible and the block is in IDLE.
- Unmasking an already-pending source raises `io_interrupt` 2 edges after the write edge: the mask updates, then the request registers.
- `io_store_retaddr` is sampled on the edge; `io_interrupt` is low the following cycle.
- EOI at edge M returns to IDLE. If an eligible source exists, `io_interrupt` is re-asserted at edge M+1.
- Push strobes have zero-cycle latency: `d_bus` is valid in the same cycle the strobe is high.
- A source whose `irq` stays high generates only one pending set, and must fall and rise again to re-request.

## Test plan

- Reset, then mask←8'h00, then `irq`[3] pulses. `io_interrupt` rises 2 edges later. `io_push_int_addr` reads 16'hFF0C.
- `irq`[5] and `irq`[2] rise in the same cycle. Source 2 is served first (vector 16'hFF08). After EOI, source 5 is requested (vector 16'hFF14).
- In REQ, with `d_addr`=16'h1234, pulse `io_store_retaddr`. `io_interrupt` drops. `io_push_retaddr` reads 16'h1234. `io_push_ints` shows `in_service`=1, id=2.
- Set mask=8'hFF, then `irq`[0] pulses. No request; `pending`=8'h01. Write mask=8'h00 and `io_interrupt` rises 2 edges later. Write CLR 8'h01 in a separate run, then unmask: no request.
- Assert `rst` while in REQ. `io_interrupt`=0 and `d_bus` is high-Z immediately. After release, mask=8'hFF and `pending`=0.
- With VECTOR_BASE=16'hFFF0 and id 7: vector wraps to 16'h000C. Holding `irq` high for 10 cycles yields only one service.

Source files
------------

// File: rtl/interrupt_controller_if.sv
// Handshake and IO-register strobes between the control unit and the interrupt controller.
// The control unit drives strobes and addresses; the controller answers with io_interrupt.
interface interrupt_controller_if;
    logic        io_interrupt;
    logic        io_store_retaddr;
    logic        io_push_retaddr;
    logic        io_push_ints;
    logic        io_push_int_addr;
    logic        io_write;
    logic [3:0]  io_addr;
    logic [15:0] d_addr;

    // io_interrupt is a level request that stays high until the cycle io_store_retaddr
    // is sampled on a rising edge; the push strobes are single-cycle combinational reads.
    modport master (
        input  io_interrupt,
        output io_store_retaddr,
        output io_push_retaddr,
        output io_push_ints,
        output io_push_int_addr,
        output io_write,
        output io_addr,
        output d_addr
    );

    modport slave (
        output io_interrupt,
        input  io_store_retaddr,
        input  io_push_retaddr,
        input  io_push_ints,
        input  io_push_int_addr,
        input  io_write,
        input  io_addr,
        input  d_addr
    );
endinterface

// File: rtl/interrupt_controller.sv
// Eight-source prioritising interrupt controller: edge-latched pending bits, software mask,
// lowest-index-wins selection and a single request/service handshake to the control unit.
module interrupt_controller #(
    parameter logic [15:0] VECTOR_BASE = 16'hFF00,
    parameter logic [3:0]  MASK_ADDR   = 4'h0,
    parameter logic [3:0]  EOI_ADDR    = 4'h1,
    parameter logic [3:0]  CLR_ADDR    = 4'h2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  irq,
    inout  wire  [15:0]                 d_bus,
    interrupt_controller_if.slave       bus,
    output logic [1:0]                  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_irq_q;
    logic [7:0]  r_pending;
    logic [7:0]  r_mask;
    logic [2:0]  r_cur_id;
    logic        r_in_service;
    logic        r_interrupt;
    logic [15:0] r_retaddr;

    logic [7:0]  w_wdata;
    logic        w_wr_mask;
    logic        w_wr_eoi;
    logic        w_wr_clr;
    logic [7:0]  w_edge;
    logic [7:0]  w_clr_bits;
    logic [7:0]  w_take_bits;
    logic [7:0]  w_eligible;
    logic [2:0]  w_sel_id;
    logic        w_load_cur;
    logic        w_take;
    logic        w_eoi;
    logic [15:0] w_vector;
    logic        w_drive_en;
    logic [15:0] w_drive_val;

    assign w_wdata    = d_bus[7:0];
    assign w_wr_mask  = bus.io_write && (bus.io_addr == MASK_ADDR);
    assign w_wr_eoi   = bus.io_write && (bus.io_addr == EOI_ADDR);
    assign w_wr_clr   = bus.io_write && (bus.io_addr == CLR_ADDR);

    assign w_edge      = irq & ~r_irq_q;
    assign w_clr_bits  = w_wr_clr ? w_wdata : 8'h00;
    assign w_take_bits = w_take ? (8'd1 << r_cur_id) : 8'h00;
    assign w_eligible  = r_pending & ~r_mask;

    always_comb begin
        w_sel_id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_sel_id = 3'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_cur  = 1'b0;
        w_take      = 1'b0;
        w_eoi       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_eligible) begin
                    w_load_cur  = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.io_store_retaddr) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (w_wr_eoi) begin
                    w_eoi       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_irq_q      <= 8'h00;
            r_pending    <= 8'h00;
            r_mask       <= 8'hFF;
            r_cur_id     <= 3'd0;
            r_in_service <= 1'b0;
            r_interrupt  <= 1'b0;
            r_retaddr    <= 16'h0000;
        end else begin
            r_state     <= w_state_nxt;
            r_irq_q     <= irq;
            r_interrupt <= (w_state_nxt == ST_REQ);
            // A fresh edge outranks both software clear and the acknowledge clear.
            r_pending   <= (r_pending & ~w_clr_bits & ~w_take_bits) | w_edge;
            if (w_wr_mask) begin
                r_mask <= w_wdata;
            end
            if (w_load_cur) begin
                r_cur_id <= w_sel_id;
            end
            if (w_take) begin
                r_retaddr    <= bus.d_addr;
                r_in_service <= 1'b1;
            end else if (w_eoi) begin
                r_in_service <= 1'b0;
            end
        end
    end

    assign w_vector = VECTOR_BASE + {11'b0, r_cur_id, 2'b00};

    always_comb begin
        w_drive_en  = 1'b0;
        w_drive_val = 16'h0000;
        if (bus.io_push_int_addr) begin
            w_drive_en  = 1'b1;
            w_drive_val = w_vector;
        end else if (bus.io_push_retaddr) begin
            w_drive_en  = 1'b1;
            w_drive_val = r_retaddr;
        end else if (bus.io_push_ints) begin
            w_drive_en  = 1'b1;
            w_drive_val = {r_cur_id, r_in_service, 4'b0000, r_pending};
        end
    end

    // Reset releases the bus immediately, independent of the clock.
    assign d_bus = (w_drive_en && !rst) ? w_drive_val : 16'hzzzz;

    assign bus.io_interrupt = r_interrupt;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed vector table, hand-written corner sequences,
// and a randomized run against a behavioural model of the pending/mask/priority rules.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    wire  [15:0] d_bus;
    logic [15:0] tb_bus;
    logic        tb_bus_en;
    logic [1:0]  dbg_state;

    logic [7:0]  irq_w;
    wire  [15:0] d_bus_w;
    logic [15:0] tb_bus_w;
    logic        tb_bus_w_en;
    logic [1:0]  dbg_state_w;

    int n_tests = 0;
    int n_fail  = 0;

    interrupt_controller_if bus ();
    interrupt_controller_if bus_w ();

    interrupt_controller u_dut (
        .clk         (clk),
        .rst         (rst),
        .irq         (irq),
        .d_bus       (d_bus),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    interrupt_controller #(.VECTOR_BASE(16'hFFF0)) u_dut_wrap (
        .clk         (clk),
        .rst         (rst),
        .irq         (irq_w),
        .d_bus       (d_bus_w),
        .bus         (bus_w),
        .o_dbg_state (dbg_state_w)
    );

    // Released bus reads back as all ones.
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup pu_main (d_bus[g]);
        pullup pu_wrap (d_bus_w[g]);
    end

    assign d_bus   = tb_bus_en   ? tb_bus   : 16'hzzzz;
    assign d_bus_w = tb_bus_w_en ? tb_bus_w : 16'hzzzz;

    // ---------------- clock / reset ----------------
    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.io_write         = 1'b0;
        bus.io_addr          = 4'h0;
        bus.io_store_retaddr = 1'b0;
        bus.io_push_retaddr  = 1'b0;
        bus.io_push_ints     = 1'b0;
        bus.io_push_int_addr = 1'b0;
        tb_bus_en            = 1'b0;
        tb_bus               = 16'h0000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        irq        = 8'h00;
        bus.d_addr = 16'h0000;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // sel: 0 vector, 1 return address, 2 status word, 3 nothing (bus released)
    task automatic push_read(input int sel, output logic [15:0] v);
        bus.io_push_int_addr = (sel == 0);
        bus.io_push_retaddr  = (sel == 1);
        bus.io_push_ints     = (sel == 2);
        #1 v = d_bus;
        bus.io_push_int_addr = 1'b0;
        bus.io_push_retaddr  = 1'b0;
        bus.io_push_ints     = 1'b0;
        #1;
    endtask

    task automatic io_wr(input logic [3:0] addr, input logic [7:0] data);
        bus.io_write = 1'b1;
        bus.io_addr  = addr;
        tb_bus_en    = 1'b1;
        tb_bus       = {8'h00, data};
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0]  irq;
        logic        wr;
        logic [3:0]  addr;
        logic [7:0]  data;
        logic        store;
        logic [15:0] d_addr;
        logic        exp_int;
        logic [15:0] exp_ints;
        logic [15:0] exp_vec;
        logic [15:0] exp_ret;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [7:0] i, input logic w, input logic [3:0] a,
                           input logic [7:0] d, input logic s, input logic [15:0] da,
                           input logic ei, input logic [15:0] es, input logic [15:0] ev,
                           input logic [15:0] er);
        vec_t v;
        v = '{i, w, a, d, s, da, ei, es, ev, er};
        vecs.push_back(v);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0]  m_pending, m_mask, m_prev;
    int          m_req_id;
    bit          m_busy;
    logic [2:0]  m_cur;
    logic [15:0] m_ret;
    logic [2:0]  exp_q[$];

    task automatic model_reset();
        m_pending = 8'h00;
        m_mask    = 8'hFF;
        m_prev    = 8'h00;
        m_req_id  = -1;
        m_busy    = 1'b0;
        m_cur     = 3'd0;
        m_ret     = 16'h0000;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [7:0] irq_n, input logic wr, input logic [3:0] addr,
                              input logic [7:0] data, input logic store, input logic [15:0] daddr);
        logic [7:0] edges, np, elig, low;
        edges = irq_n & ~m_prev;
        np    = m_pending & ~((wr && addr == 4'h2) ? data : 8'h00);
        elig  = m_pending & ~m_mask;
        if (m_req_id >= 0) begin
            if (store) begin
                np = np & ~(8'd1 << m_req_id);
                exp_q.push_back(3'(m_req_id));
                m_ret    = daddr;
                m_busy   = 1'b1;
                m_req_id = -1;
            end
        end else if (m_busy) begin
            if (wr && addr == 4'h1) m_busy = 1'b0;
        end else if (elig != 8'h00) begin
            low      = elig & (~elig + 8'd1);
            m_req_id = $clog2(low);
            m_cur    = 3'(m_req_id);
        end
        m_pending = np | edges;
        if (wr && addr == 4'h0) m_mask = data;
        m_prev = irq_n;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] v;
        vec_t        cv;
        int          services;
        logic [7:0]  r_irq, r_data;
        logic        r_wr, r_store;
        logic [3:0]  r_addr;
        logic [15:0] r_daddr;
        logic [15:0] ints;

        irq_w                  = 8'h00;
        tb_bus_w_en            = 1'b0;
        tb_bus_w               = 16'h0000;
        bus_w.io_write         = 1'b0;
        bus_w.io_addr          = 4'h0;
        bus_w.io_store_retaddr = 1'b0;
        bus_w.io_push_retaddr  = 1'b0;
        bus_w.io_push_ints     = 1'b0;
        bus_w.io_push_int_addr = 1'b0;
        bus_w.d_addr           = 16'h0000;
        do_reset();

        // reset state
        check("rst_int", 16'(bus.io_interrupt), 16'd0);
        check("rst_state", 16'(dbg_state), 16'd0);
        push_read(2, v); check("rst_ints", v, 16'h0000);
        push_read(0, v); check("rst_vec", v, 16'hFF00);
        push_read(1, v); check("rst_ret", v, 16'h0000);
        push_read(3, v); check("rst_release", v, 16'hFFFF);

        // vector wrap on the second instance, id 7 with base FFF0
        bus_w.io_write = 1'b1; bus_w.io_addr = 4'h0; tb_bus_w_en = 1'b1; tb_bus_w = 16'h0000;
        tick();
        bus_w.io_write = 1'b0; tb_bus_w_en = 1'b0; irq_w = 8'h80;
        tick();
        irq_w = 8'h00;
        tick();
        check("wrap_int", 16'(bus_w.io_interrupt), 16'd1);
        bus_w.io_push_int_addr = 1'b1;
        #1 check("wrap_vec", d_bus_w, 16'h000C);
        bus_w.io_push_int_addr = 1'b0;

        //       irq  wr addr data st d_addr   int  ints     vec      ret
        add_vec(8'h00,1,4'h0,8'h00,0,16'h0000, 0,16'h0000,16'hFF00,16'h0000);
        add_vec(8'h08,0,4'h0,8'h00,0,16'h0000, 0,16'h0008,16'hFF00,16'h0000);
        add_vec(8'h00,0,4'h0,8'h00,0,16'h0000, 1,16'h6008,16'hFF0C,16'h0000);
        add_vec(8'h00,0,4'h0,8'h00,1,16'hABCD, 0,16'h7000,16'hFF0C,16'hABCD);
        add_vec(8'h00,1,4'h1,8'h00,0,16'h0000, 0,16'h6000,16'hFF0C,16'hABCD);
        add_vec(8'h24,0,4'h0,8'h00,0,16'h0000, 0,16'h6024,16'hFF0C,16'hABCD);
        add_vec(8'h24,0,4'h0,8'h00,0,16'h0000, 1,16'h4024,16'hFF08,16'hABCD);
        add_vec(8'h00,0,4'h0,8'h00,1,16'h1234, 0,16'h5020,16'hFF08,16'h1234);
        add_vec(8'h00,0,4'h0,8'h00,1,16'h5555, 0,16'h5020,16'hFF08,16'h1234);
        add_vec(8'h00,1,4'h1,8'h00,0,16'h0000, 0,16'h4020,16'hFF08,16'h1234);
        add_vec(8'h00,0,4'h0,8'h00,0,16'h0000, 1,16'hA020,16'hFF14,16'h1234);
        add_vec(8'h00,1,4'h0,8'hFF,0,16'h0000, 1,16'hA020,16'hFF14,16'h1234);
        add_vec(8'h01,0,4'h0,8'h00,0,16'h0000, 1,16'hA021,16'hFF14,16'h1234);
        add_vec(8'h00,0,4'h0,8'h00,1,16'h0BEE, 0,16'hB001,16'hFF14,16'h0BEE);
        add_vec(8'h00,1,4'h1,8'h00,0,16'h0000, 0,16'hA001,16'hFF14,16'h0BEE);
        add_vec(8'h00,0,4'h0,8'h00,0,16'h0000, 0,16'hA001,16'hFF14,16'h0BEE);
        add_vec(8'h00,1,4'h0,8'h00,0,16'h0000, 0,16'hA001,16'hFF14,16'h0BEE);
        add_vec(8'h00,0,4'h0,8'h00,0,16'h0000, 1,16'h0001,16'hFF00,16'h0BEE);
        add_vec(8'h00,0,4'h0,8'h00,1,16'h4321, 0,16'h1000,16'hFF00,16'h4321);
        add_vec(8'h00,1,4'h1,8'h00,0,16'h0000, 0,16'h0000,16'hFF00,16'h4321);
        add_vec(8'h00,1,4'h0,8'hFF,0,16'h0000, 0,16'h0000,16'hFF00,16'h4321);
        add_vec(8'h01,0,4'h0,8'h00,0,16'h0000, 0,16'h0001,16'hFF00,16'h4321);
        add_vec(8'h00,1,4'h2,8'h01,0,16'h0000, 0,16'h0000,16'hFF00,16'h4321);
        add_vec(8'h00,1,4'h0,8'h00,0,16'h0000, 0,16'h0000,16'hFF00,16'h4321);
        add_vec(8'h00,0,4'h0,8'h00,0,16'h0000, 0,16'h0000,16'hFF00,16'h4321);
        add_vec(8'h02,1,4'h2,8'h02,0,16'h0000, 0,16'h0002,16'hFF00,16'h4321);
        add_vec(8'h02,0,4'h0,8'h00,0,16'h0000, 1,16'h2002,16'hFF04,16'h4321);
        add_vec(8'h02,1,4'h2,8'h02,0,16'h0000, 1,16'h2000,16'hFF04,16'h4321);
        add_vec(8'h02,0,4'h0,8'h00,1,16'h7777, 0,16'h3000,16'hFF04,16'h7777);
        add_vec(8'h00,1,4'h1,8'h00,0,16'h0000, 0,16'h2000,16'hFF04,16'h7777);
        add_vec(8'h00,1,4'hF,8'hFF,0,16'h0000, 0,16'h2000,16'hFF04,16'h7777);
        add_vec(8'h10,0,4'h0,8'h00,0,16'h0000, 0,16'h2010,16'hFF04,16'h7777);
        add_vec(8'h00,0,4'h0,8'h00,0,16'h0000, 1,16'h8010,16'hFF10,16'h7777);
        add_vec(8'h00,0,4'h0,8'h00,1,16'h0000, 0,16'h9000,16'hFF10,16'h0000);
        add_vec(8'h00,1,4'h1,8'h00,0,16'h0000, 0,16'h8000,16'hFF10,16'h0000);

        foreach (vecs[k]) begin
            cv = vecs[k];
            irq = cv.irq;
            bus.d_addr = cv.d_addr;
            bus.io_store_retaddr = cv.store;
            if (cv.wr) io_wr(cv.addr, cv.data);
            tick();
            idle_inputs();
            check($sformatf("vec%0d_int", k), 16'(bus.io_interrupt), 16'(cv.exp_int));
            push_read(2, v); check($sformatf("vec%0d_ints", k), v, cv.exp_ints);
            push_read(0, v); check($sformatf("vec%0d_vec", k), v, cv.exp_vec);
            push_read(1, v); check($sformatf("vec%0d_ret", k), v, cv.exp_ret);
        end

        // push priority: vector > return address > status
        bus.io_push_int_addr = 1'b1; bus.io_push_retaddr = 1'b1; bus.io_push_ints = 1'b1;
        #1 check("prio_all", d_bus, 16'hFF10);
        bus.io_push_int_addr = 1'b0;
        #1 check("prio_ret_ints", d_bus, 16'h0000);
        bus.io_push_retaddr = 1'b0; bus.io_push_ints = 1'b0;
        #1 check("prio_release", d_bus, 16'hFFFF);
        tick();

        // a level held high is serviced exactly once
        irq = 8'h40;
        services = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 10) irq = 8'h00;
            if (bus.io_interrupt) begin
                bus.io_store_retaddr = 1'b1;
                services++;
            end else if (dbg_state == 2'd2) begin
                io_wr(4'h1, 8'h00);
            end
            tick();
            idle_inputs();
        end
        check("hold_services", 16'(services), 16'd1);
        check("hold_no_req", 16'(bus.io_interrupt), 16'd0);
        check("hold_idle", 16'(dbg_state), 16'd0);

        // asynchronous reset while a request is outstanding
        irq = 8'h08;
        tick();
        irq = 8'h00;
        tick();
        check("arst_pre_int", 16'(bus.io_interrupt), 16'd1);
        bus.io_push_ints = 1'b1;
        #3 rst = 1'b1;
        #1 check("arst_int", 16'(bus.io_interrupt), 16'd0);
        check("arst_release", d_bus, 16'hFFFF);
        check("arst_state", 16'(dbg_state), 16'd0);
        tick();
        rst = 1'b0;
        bus.io_push_ints = 1'b0;
        push_read(2, v); check("arst_ints", v, 16'h0000);
        irq = 8'h01;
        tick();
        irq = 8'h00;
        tick();
        tick();
        check("arst_masked_int", 16'(bus.io_interrupt), 16'd0);
        push_read(2, v); check("arst_masked_pend", v, 16'h0001);

        // randomized run against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            check("rnd_int", 16'(bus.io_interrupt), (m_req_id >= 0) ? 16'd1 : 16'd0);
            push_read(2, ints);
            check("rnd_ints", ints, {m_cur, m_busy, 4'b0000, m_pending});
            push_read(0, v); check("rnd_vec", v, 16'hFF00 + {11'b0, m_cur, 2'b00});
            push_read(1, v); check("rnd_ret", v, m_ret);
            if (exp_q.size() > 0) check("rnd_served_id", 16'(ints[15:13]), 16'(exp_q.pop_front()));

            r_irq   = irq ^ (($urandom_range(0, 2) == 0) ? (8'($urandom) & 8'($urandom)) : 8'h00);
            r_wr    = ($urandom_range(0, 3) == 0);
            r_addr  = 4'($urandom_range(0, 3));
            r_data  = (r_addr == 4'h0 && $urandom_range(0, 3) != 0) ? 8'h00 : 8'($urandom);
            r_store = ($urandom_range(0, 2) == 0);
            r_daddr = 16'($urandom);

            irq = r_irq;
            bus.d_addr = r_daddr;
            bus.io_store_retaddr = r_store;
            if (r_wr) io_wr(r_addr, r_data);
            tick();
            idle_inputs();
            model_step(r_irq, r_wr, r_addr, r_data, r_store, r_daddr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
